// File: rtl/div_restoring_seq_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the sequential restoring divider.
//   DEF_WIDTH   : default operand/quotient/remainder width
//   DEF_CNT_W   : step-counter width for DEF_WIDTH
//   cnt_width() : step-counter width for an arbitrary WIDTH
//   div_state_e : control FSM states
// ---------------------------------------------------------------------------
package div_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

  // Counter must hold values 0..WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a request
    RUN  = 2'd1,  // one restoring step per clock
    DONE = 2'd2   // result presented until accepted
  } div_state_e;

endpackage

// File: rtl/div_restoring_seq_if.sv
// ---------------------------------------------------------------------------
// div_restoring_seq_if
// Request/response bundle of the divider.
//   Request : I0 (dividend), I1 (divisor), I_valid -> / <- I_ready
//   Response: O (quotient), R (remainder), DIV0, O_valid -> / <- O_ready
// Modports: slave = divider side, master = requester side.
// ---------------------------------------------------------------------------
interface div_restoring_seq_if
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  logic             I_valid;
  logic             I_ready;
  logic [WIDTH-1:0] O;
  logic [WIDTH-1:0] R;
  logic             DIV0;
  logic             O_valid;
  logic             O_ready;

  modport slave (
    input  I0, I1, I_valid, O_ready,
    output I_ready, O, R, DIV0, O_valid
  );

  modport master (
    output I0, I1, I_valid, O_ready,
    input  I_ready, O, R, DIV0, O_valid
  );
endinterface

// File: rtl/div_restoring_seq_sub_cout.sv
// ---------------------------------------------------------------------------
// sub_cout
// W-bit subtractor built as a + ~b + 1. The carry-out is the not-borrow:
// cout_o = 1 exactly when a_i >= b_i (unsigned).
//   a_i, b_i : operands
//   diff_o   : a_i - b_i modulo 2^W
//   cout_o   : carry-out of the addition
// ---------------------------------------------------------------------------
module sub_cout #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         cout_o
);
  logic cin;

  assign cin = 1'b1;
  assign {cout_o, diff_o} = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, cin};
endmodule

// File: rtl/div_restoring_seq.sv
// ---------------------------------------------------------------------------
// div_restoring_seq
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// An accepted request produces its result exactly WIDTH cycles later,
// independent of operand values. A zero divisor runs the same algorithm and
// naturally yields O = all ones, R = dividend, flagged by DIV0.
//   CLK         : clock, rising edge
//   ASYNCRESETN : asynchronous active-low reset
//   bus         : slave side of div_restoring_seq_if (request/response)
// ---------------------------------------------------------------------------
module div_restoring_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic                CLK,
  input logic                ASYNCRESETN,
  div_restoring_seq_if.slave bus
);
  localparam int CNT_W = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shift register
  logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor
  logic [WIDTH:0]   rem_q, rem_d;   // partial remainder, one guard bit
  logic [WIDTH-1:0] quo_q, quo_d;   // quotient shift register
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             div0_q, div0_d;

  logic             i_ready, o_valid;
  logic [WIDTH:0]   rem_shift, trial;
  logic             no_borrow;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;

  // After a restore the remainder is below the divisor, so the guard bit of
  // the stored remainder is always zero and is dropped when shifting.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[WIDTH];

  assign rem_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};

  sub_cout #(.W(WIDTH + 1)) u_sub (
    .a_i    (rem_shift),
    .b_i    ({1'b0, dvs_q}),
    .diff_o (trial),
    .cout_o (no_borrow)
  );

  assign rem_step = no_borrow ? trial : rem_shift;
  assign quo_step = {quo_q[WIDTH-2:0], no_borrow};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // combinational output unassigned, which would infer a latch.
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    r_d     = r_q;
    div0_d  = div0_q;
    i_ready = 1'b0;
    o_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        i_ready = 1'b1;
        if (bus.I_valid) begin
          dvd_d   = bus.I0;
          dvs_d   = bus.I1;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CNT_W'(1);
        // The last step's results are loaded straight into the outputs.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          o_d     = quo_step;
          r_d     = rem_step[WIDTH-1:0];
          div0_d  = (dvs_q == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (bus.O_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values computed above, regardless of statement order.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      r_q     <= r_d;
      div0_q  <= div0_d;
    end
  end

  assign bus.I_ready = i_ready;
  assign bus.O_valid = o_valid;
  assign bus.O       = o_q;
  assign bus.R       = r_q;
  assign bus.DIV0    = div0_q;
endmodule

// File: tb/tb_div_restoring_seq.sv
// ---------------------------------------------------------------------------
// tb_div_restoring_seq
// Directed bench for div_restoring_seq. Expected results are computed from
// the operands when a request is issued, queued, and compared when the
// divider presents its result.
// ---------------------------------------------------------------------------
module tb_div_restoring_seq;
  localparam int WIDTH = 8;

  logic CLK = 1'b0;
  logic ASYNCRESETN;

  always #5 CLK = ~CLK;

  div_restoring_seq_if #(.WIDTH(WIDTH)) bus ();

  div_restoring_seq #(.WIDTH(WIDTH)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .bus         (bus)
  );

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
    logic [WIDTH-1:0] dvs;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Waits for I_ready, presents one request, and queues its expected result.
  task automatic send(input int a, input int b);
    int   waited = 0;
    exp_t e;
    @(negedge CLK);
    while (bus.I_ready !== 1'b1 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    check("req_ready_wait", 32'(waited < 20), 32'd1);
    bus.I0      = WIDTH'(a);
    bus.I1      = WIDTH'(b);
    bus.I_valid = 1'b1;
    e.dvs = WIDTH'(b);
    if (b == 0) begin
      e.q  = '1;
      e.r  = WIDTH'(a);
      e.dz = 1'b1;
    end else begin
      e.q  = WIDTH'(a / b);
      e.r  = WIDTH'(a % b);
      e.dz = 1'b0;
    end
    sb.push_back(e);
    @(posedge CLK);
    #1 bus.I_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until O_valid, checks latency and the
  // queued result, optionally holds O_ready low for `hold` cycles, then
  // completes the handshake. At cycle `pulse_cyc` a stray request is driven.
  task automatic wait_result(input string tag, input int pulse_cyc, input int hold);
    int   cyc = 0;
    logic got = 1'b0;
    exp_t e;
    while (!got && cyc < WIDTH + 4) begin
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
      if (bus.O_valid === 1'b1) begin
        got = 1'b1;
      end else begin
        check({tag, "_run_ready"}, 32'(bus.I_ready), 32'd0);
        if (cyc == pulse_cyc) begin
          bus.I0      = WIDTH'(50);
          bus.I1      = WIDTH'(5);
          bus.I_valid = 1'b1;
        end else begin
          bus.I_valid = 1'b0;
        end
      end
    end
    bus.I_valid = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(WIDTH));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_O"}, 32'(bus.O), 32'(e.q));
      check({tag, "_R"}, 32'(bus.R), 32'(e.r));
      check({tag, "_DIV0"}, 32'(bus.DIV0), 32'(e.dz));
      if (e.dvs != '0) check({tag, "_R_lt_div"}, 32'(bus.R < e.dvs), 32'd1);
      for (int i = 0; i < hold; i++) begin
        @(posedge CLK);
        @(negedge CLK);
        check({tag, "_hold_valid"}, 32'(bus.O_valid), 32'd1);
        check({tag, "_hold_O"}, 32'(bus.O), 32'(e.q));
        check({tag, "_hold_R"}, 32'(bus.R), 32'(e.r));
        check({tag, "_hold_ready"}, 32'(bus.I_ready), 32'd0);
      end
    end
    bus.O_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check({tag, "_after_I_ready"}, 32'(bus.I_ready), 32'd1);
    check({tag, "_after_O_valid"}, 32'(bus.O_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    exp_t dropped;
    logic seen;

    bus.I0      = '0;
    bus.I1      = '0;
    bus.I_valid = 1'b0;
    bus.O_ready = 1'b1;
    ASYNCRESETN = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    @(negedge CLK);
    check("rst_I_ready", 32'(bus.I_ready), 32'd1);
    check("rst_O_valid", 32'(bus.O_valid), 32'd0);
    check("rst_O", 32'(bus.O), 32'd0);
    check("rst_R", 32'(bus.R), 32'd0);
    check("rst_DIV0", 32'(bus.DIV0), 32'd0);

    // Basic operation and boundaries
    send(100, 7);   wait_result("d100_7", 0, 0);
    send(255, 1);   wait_result("d255_1", 0, 0);
    send(3, 10);    wait_result("d3_10", 0, 0);
    send(200, 200); wait_result("d200_200", 0, 0);
    send(5, 0);     wait_result("d5_0", 0, 0);
    send(0, 255);   wait_result("d0_255", 0, 0);

    // Downstream back-pressure
    bus.O_ready = 1'b0;
    send(77, 9);    wait_result("d77_9_hold", 0, 5);

    // Stray request during RUN must be ignored
    send(100, 7);   wait_result("d100_7_pulse", 3, 0);

    // Asynchronous reset in the middle of RUN
    send(100, 7);
    dropped = sb.pop_back();
    repeat (4) @(posedge CLK);
    #2 ASYNCRESETN = 1'b0;
    #1;
    check("midrst_O_valid", 32'(bus.O_valid), 32'd0);
    check("midrst_I_ready", 32'(bus.I_ready), 32'd1);
    check("midrst_O", 32'(bus.O), 32'd0);
    check("midrst_R", 32'(bus.R), 32'd0);
    check("midrst_DIV0", 32'(bus.DIV0), 32'd0);
    #1 ASYNCRESETN = 1'b1;
    seen = 1'b0;
    repeat (WIDTH + 4) begin
      @(negedge CLK);
      if (bus.O_valid === 1'b1) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    check("midrst_dropped_q", 32'(dropped.q), 32'd14);

    send(60, 8);    wait_result("d60_8", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
